// File: rtl/gps_iq_deser_if.sv
// Port bundle for gps_iq_deser: demodulator serial link, CPU FIFO read side and status flags.
// The slave modport is the deserializer's view; the master modport belongs to whoever drives it.
interface gps_iq_deser_if #(
    parameter int INTEG_BITS = 20,
    parameter int DEPTH      = 32,
    parameter int CNT_BITS   = 8
);
    logic                       enable;
    logic                       epoch;
    logic                       sin;
    logic                       shift;
    logic                       rd_en;
    logic [INTEG_BITS-1:0]      rd_data;
    logic                       rd_empty;
    logic [$clog2(DEPTH):0]     level;
    logic                       busy;
    logic                       set_done;
    logic                       overrun;
    logic [CNT_BITS-1:0]        dropped;
    logic                       clr_flags;

    modport slave (
        input  enable, epoch, sin, rd_en, clr_flags,
        output shift, rd_data, rd_empty, level, busy, set_done, overrun, dropped
    );

    modport master (
        output enable, epoch, sin, rd_en, clr_flags,
        input  shift, rd_data, rd_empty, level, busy, set_done, overrun, dropped
    );
endinterface

// File: rtl/gps_iq_deser.sv
// Captures the demodulator's serialized E/P/L I/Q snapshot into a show-ahead FIFO.
// Fields are staged behind a committed write pointer so a whole snapshot appears atomically.
module gps_iq_deser #(
    parameter int INTEG_BITS = 20,
    parameter int NFIELDS    = 6,
    parameter int DEPTH      = 32,
    parameter int CNT_BITS   = 8
) (
    input  logic               clk,
    input  logic               rst,
    gps_iq_deser_if.slave      io
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (INTEG_BITS > 1) ? $clog2(INTEG_BITS) : 1;
    localparam int FW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [INTEG_BITS-1:0]  mem [DEPTH];
    logic [AW:0]            wptr, wcmt, rptr;
    logic [BW-1:0]          bit_cnt;
    logic [FW-1:0]          fld_cnt;
    logic [INTEG_BITS-1:0]  sr;
    logic [INTEG_BITS-1:0]  push_data;
    logic                   push_vld, push_last;
    logic                   busy, set_done, overrun;
    logic [CNT_BITS-1:0]    dropped;

    logic [AW:0]            level;
    logic [AW+1:0]          room;
    logic                   room_ok, empty, start, abort, pop, push_ok;
    logic [INTEG_BITS-1:0]  sr_next;

    assign level   = wcmt - rptr;
    assign empty   = (level == '0);
    assign room    = (AW+2)'(DEPTH) - {1'b0, level};
    assign room_ok = (room >= (AW+2)'(NFIELDS));
    assign start   = io.epoch & io.enable;
    // An epoch any time busy is high (including the final push cycle) voids the snapshot.
    assign abort   = start & busy;
    assign pop     = io.rd_en & ~empty;
    assign push_ok = push_vld & ~abort;
    assign sr_next = {sr[INTEG_BITS-2:0], io.sin};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wptr      <= '0;
            wcmt      <= '0;
            rptr      <= '0;
            bit_cnt   <= '0;
            fld_cnt   <= '0;
            sr        <= '0;
            push_data <= '0;
            push_vld  <= 1'b0;
            push_last <= 1'b0;
            busy      <= 1'b0;
            set_done  <= 1'b0;
            overrun   <= 1'b0;
            dropped   <= '0;
        end else begin
            set_done  <= 1'b0;
            push_vld  <= 1'b0;
            push_last <= 1'b0;

            if (io.clr_flags) begin
                overrun <= 1'b0;
                dropped <= '0;
            end

            if (pop) rptr <= rptr + PTR_ONE;

            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
                if (push_last) begin
                    wcmt <= wptr + PTR_ONE;
                    busy <= 1'b0;
                end
            end

            if (start) begin
                if (abort) begin
                    overrun <= 1'b1;
                    wptr    <= wcmt;
                end
                bit_cnt <= '0;
                fld_cnt <= '0;
                if (room_ok) begin
                    state <= SHIFT;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (dropped != {CNT_BITS{1'b1}}) dropped <= dropped + 1'b1;
                end
            end else if (state == SHIFT) begin
                sr <= sr_next;
                if (bit_cnt == BW'(INTEG_BITS-1)) begin
                    bit_cnt   <= '0;
                    push_vld  <= 1'b1;
                    push_data <= sr_next;
                    if (fld_cnt == FW'(NFIELDS-1)) begin
                        state     <= IDLE;
                        fld_cnt   <= '0;
                        push_last <= 1'b1;
                        set_done  <= 1'b1;
                    end else begin
                        fld_cnt <= fld_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign io.shift    = (state == SHIFT);
    assign io.rd_data  = empty ? '0 : mem[rptr[AW-1:0]];
    assign io.rd_empty = empty;
    assign io.level    = level;
    assign io.busy     = busy;
    assign io.set_done = set_done;
    assign io.overrun  = overrun;
    assign io.dropped  = dropped;
endmodule

// File: tb/tb_gps_iq_deser.sv
// Directed bench for gps_iq_deser: table-driven pops plus hand sequences for overrun,
// back-pressure, mid-readout reset and drop-counter saturation.
module tb_gps_iq_deser;
    localparam int IB = 20;
    localparam int NF = 6;
    localparam int DP = 32;
    localparam int CB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gps_iq_deser_if #(.INTEG_BITS(IB), .DEPTH(DP), .CNT_BITS(CB)) io();

    gps_iq_deser #(.INTEG_BITS(IB), .NFIELDS(NF), .DEPTH(DP), .CNT_BITS(CB)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        logic [19:0] exp_data;
        logic [5:0]  exp_level;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    logic [19:0] model[$];

    localparam logic [119:0] PAT_A = {20'h12345, 20'hFFFFF, 20'h00001, 20'h80000, 20'h7FFFF, 20'h0ABCD};
    localparam logic [119:0] PAT_B = {20'hA5A5A, 20'h5A5A5, 20'h00000, 20'hFFFFE, 20'h13579, 20'h2468A};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pop_n(input int n);
        for (int k = 0; k < n; k++) begin
            chk("pop_data", 32'(io.rd_data), 32'(model[0]));
            io.rd_en = 1'b1;
            tick();
            io.rd_en = 1'b0;
            void'(model.pop_front());
        end
    endtask

    // abort_at >= 0 injects an epoch (or reset when do_rst) during that bit of the readout.
    task automatic run_snap(input logic [119:0] pat, input int abort_at, input bit do_rst, input bit pop_run);
        int shifts;
        int ab;
        logic [31:0] lvl0;
        shifts = 0;
        ab = abort_at;
        lvl0 = 32'(io.level);
        chk("shift_idle_pre", 32'(io.shift), 32'd0);
        io.epoch = 1'b1;
        tick();
        io.epoch = 1'b0;
        for (int i = 0; i < 120; i++) begin
            io.sin = pat[119-i];
            io.rd_en = 1'b0;
            if (io.shift) shifts++;
            if (pop_run && i < 6) begin
                chk("pop_during_readout", 32'(io.rd_data), 32'(model[0]));
                io.rd_en = 1'b1;
                void'(model.pop_front());
            end
            if (i == ab) begin
                if (do_rst) rst = 1'b1;
                else io.epoch = 1'b1;
            end
            tick();
            io.epoch = 1'b0;
            io.rd_en = 1'b0;
            if (i == ab) begin
                if (do_rst) begin
                    chk("rst_shift", 32'(io.shift), 32'd0);
                    chk("rst_level", 32'(io.level), 32'd0);
                    chk("rst_empty", 32'(io.rd_empty), 32'd1);
                    chk("rst_busy", 32'(io.busy), 32'd0);
                    model.delete();
                    rst = 1'b0;
                    tick();
                    return;
                end
                chk("ovr_flag", 32'(io.overrun), 32'd1);
                chk("ovr_level_kept", 32'(io.level), lvl0);
                chk("ovr_restart_shift", 32'(io.shift), 32'd1);
                shifts = 0;
                ab = -1;
                i = -1;
            end
        end
        chk("shift_count", 32'(shifts), 32'd120);
        chk("shift_end", 32'(io.shift), 32'd0);
        chk("set_done_pulse", 32'(io.set_done), 32'd1);
        chk("busy_final_push", 32'(io.busy), 32'd1);
        tick();
        for (int f = 0; f < NF; f++) model.push_back(pat[119-20*f -: 20]);
        chk("set_done_clear", 32'(io.set_done), 32'd0);
        chk("busy_clear", 32'(io.busy), 32'd0);
        chk("level_commit", 32'(io.level), 32'(model.size()));
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{20'h12345, 6'd6};
        tbl[1] = '{20'hFFFFF, 6'd5};
        tbl[2] = '{20'h00001, 6'd4};
        tbl[3] = '{20'h80000, 6'd3};
        tbl[4] = '{20'h7FFFF, 6'd2};
        tbl[5] = '{20'h0ABCD, 6'd1};

        rst = 1'b1;
        io.enable = 1'b1; io.epoch = 1'b0; io.sin = 1'b0; io.rd_en = 1'b0; io.clr_flags = 1'b0;
        tick(); tick();
        chk("rst_shift0", 32'(io.shift), 32'd0);
        chk("rst_busy0", 32'(io.busy), 32'd0);
        chk("rst_set_done0", 32'(io.set_done), 32'd0);
        chk("rst_overrun0", 32'(io.overrun), 32'd0);
        chk("rst_dropped0", 32'(io.dropped), 32'd0);
        chk("rst_level0", 32'(io.level), 32'd0);
        chk("rst_empty0", 32'(io.rd_empty), 32'd1);
        chk("rst_rd_data0", 32'(io.rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // Basic snapshot, drained against hand-computed values
        run_snap(PAT_A, -1, 1'b0, 1'b0);
        for (int v = 0; v < 6; v++) begin
            chk("tbl_level", 32'(io.level), 32'(tbl[v].exp_level));
            chk("tbl_data", 32'(io.rd_data), 32'(tbl[v].exp_data));
            io.rd_en = 1'b1;
            tick();
            io.rd_en = 1'b0;
            void'(model.pop_front());
        end
        chk("tbl_empty", 32'(io.rd_empty), 32'd1);
        chk("tbl_rd_data_empty", 32'(io.rd_data), 32'd0);

        // Pops during a second readout see only the committed snapshot
        run_snap(PAT_A, -1, 1'b0, 1'b0);
        run_snap(PAT_B, -1, 1'b0, 1'b1);
        chk("pop_run_level", 32'(io.level), 32'd6);
        chk("pop_run_head", 32'(io.rd_data), 32'h A5A5A);

        // Reset at bit 70, then a normal readout
        run_snap(PAT_A, 70, 1'b1, 1'b0);
        run_snap(PAT_A, -1, 1'b0, 1'b0);
        chk("post_rst_level", 32'(io.level), 32'd6);

        // Overrun at bit 50
        run_snap(PAT_B, 50, 1'b0, 1'b0);
        chk("ovr_level_after", 32'(io.level), 32'd12);

        // Back-pressure: fill to 30, pop to 28, epoch must drop
        run_snap(PAT_B, -1, 1'b0, 1'b0);
        run_snap(PAT_A, -1, 1'b0, 1'b0);
        run_snap(PAT_B, -1, 1'b0, 1'b0);
        pop_n(2);
        chk("fill_level28", 32'(io.level), 32'd28);
        io.epoch = 1'b1;
        tick();
        io.epoch = 1'b0;
        chk("drop_no_shift", 32'(io.shift), 32'd0);
        chk("drop_count1", 32'(io.dropped), 32'd1);
        chk("drop_level28", 32'(io.level), 32'd28);
        tick();
        chk("drop_no_shift2", 32'(io.shift), 32'd0);
        pop_n(2);
        run_snap(PAT_A, -1, 1'b0, 1'b0);
        chk("full_level32", 32'(io.level), 32'd32);

        // Drop counter saturation and flag clear
        io.epoch = 1'b1;
        repeat (300) tick();
        io.epoch = 1'b0;
        chk("drop_sat", 32'(io.dropped), 32'd255);
        chk("ovr_sticky", 32'(io.overrun), 32'd1);
        chk("sat_level32", 32'(io.level), 32'd32);
        io.clr_flags = 1'b1;
        tick();
        io.clr_flags = 1'b0;
        chk("clr_dropped", 32'(io.dropped), 32'd0);
        chk("clr_overrun", 32'(io.overrun), 32'd0);

        // Clear coinciding with a drop: the drop is still counted
        io.clr_flags = 1'b1;
        io.epoch = 1'b1;
        tick();
        io.clr_flags = 1'b0;
        io.epoch = 1'b0;
        chk("clr_vs_drop", 32'(io.dropped), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
